// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM slave: FSM state encoding, frame command codes
// and the rule for which command each payload state accepts.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // WRITE takes either write command; each read state takes only its own command.
  function automatic logic cmd_legal(input state_t st, input logic [1:0] cmd);
    case (st)
      WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  return (cmd == CMD_RD_ADDR);
      READ_DATA: return (cmd == CMD_RD_DATA);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_ram_sp.sv
// Single-port RAM with synchronous write and registered read; contents are never reset.
module spi_ram_sp #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    // Addresses beyond the populated depth are ignored on write.
    if (we && (int'(addr) < MEM_DEPTH)) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_slave_ram_gen.sv
// SPI slave fronting a single-port RAM: frames carry a 2-bit command plus a DATA_W payload
// to set write/read addresses, write a word, or read a word back serially on MISO.
module spi_slave_ram_gen
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int OCNT_W  = $clog2(DATA_W + 1);

  state_t              state_reg;
  logic [FRAME_W-1:0]  shift_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                done_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic                rd_addr_valid_reg;
  logic                rd_pend_reg;
  logic [DATA_W-1:0]   out_sr_reg;
  logic [OCNT_W-1:0]   out_cnt_reg;
  logic                miso_reg;
  logic                frame_err_reg;

  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic                in_payload;
  logic                decode;
  logic                legal;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (AUTO_INC == 0) return a;
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign cmd        = shift_reg[FRAME_W-1 -: 2];
  assign payload    = shift_reg[DATA_W-1:0];
  assign in_payload = (state_reg == WRITE) || (state_reg == READ_ADD) || (state_reg == READ_DATA);
  // The command is acted on one edge after the last payload bit was shifted in.
  assign decode     = in_payload && (bit_cnt_reg == CNT_W'(FRAME_W)) && !done_reg;
  assign legal      = cmd_legal(state_reg, cmd);
  assign ram_we     = decode && legal && (cmd == CMD_WR_DATA);
  assign ram_addr   = (state_reg == READ_DATA) ? rd_addr_reg : wr_addr_reg;

  spi_ram_sp #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      shift_reg         <= '0;
      bit_cnt_reg       <= '0;
      done_reg          <= 1'b0;
      wr_addr_reg       <= '0;
      rd_addr_reg       <= '0;
      rd_addr_valid_reg <= 1'b0;
      rd_pend_reg       <= 1'b0;
      out_sr_reg        <= '0;
      out_cnt_reg       <= '0;
      miso_reg          <= 1'b0;
      frame_err_reg     <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      rd_pend_reg   <= 1'b0;

      // Readout: RAM word arrives one cycle after the read decode, then shifts out MSB first.
      if (rd_pend_reg) begin
        miso_reg    <= ram_rdata[DATA_W-1];
        out_sr_reg  <= {ram_rdata[DATA_W-2:0], 1'b0};
        out_cnt_reg <= OCNT_W'(DATA_W - 1);
      end else if (out_cnt_reg != '0) begin
        miso_reg    <= out_sr_reg[DATA_W-1];
        out_sr_reg  <= {out_sr_reg[DATA_W-2:0], 1'b0};
        out_cnt_reg <= out_cnt_reg - OCNT_W'(1);
      end else begin
        miso_reg    <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!SS_n) begin
            state_reg   <= CHK_CMD;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            done_reg    <= 1'b0;
          end
        end

        CHK_CMD: begin
          if (SS_n) begin
            state_reg     <= IDLE;
            frame_err_reg <= 1'b1;
          end else if (!MOSI) begin
            state_reg <= WRITE;
          end else if (rd_addr_valid_reg) begin
            state_reg <= READ_DATA;
          end else begin
            state_reg <= READ_ADD;
          end
        end

        default: begin
          if (decode) begin
            done_reg <= 1'b1;
            if (legal) begin
              case (cmd)
                CMD_WR_ADDR: wr_addr_reg <= payload[ADDR_W-1:0];
                CMD_WR_DATA: wr_addr_reg <= next_addr(wr_addr_reg);
                CMD_RD_ADDR: begin
                  rd_addr_reg       <= payload[ADDR_W-1:0];
                  rd_addr_valid_reg <= 1'b1;
                end
                default: begin
                  rd_addr_reg       <= next_addr(rd_addr_reg);
                  rd_addr_valid_reg <= 1'b0;
                  rd_pend_reg       <= 1'b1;
                end
              endcase
            end else begin
              frame_err_reg <= 1'b1;
            end
            if (SS_n) begin
              state_reg   <= IDLE;
              rd_pend_reg <= 1'b0;
              out_cnt_reg <= '0;
              miso_reg    <= 1'b0;
            end
          end else if (done_reg) begin
            // Completed frame: only a rising SS_n ends it, cutting any readout short.
            if (SS_n) begin
              state_reg   <= IDLE;
              rd_pend_reg <= 1'b0;
              out_cnt_reg <= '0;
              miso_reg    <= 1'b0;
            end
          end else if (SS_n) begin
            state_reg     <= IDLE;
            frame_err_reg <= 1'b1;
          end else begin
            shift_reg   <= {shift_reg[FRAME_W-2:0], MOSI};
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign MISO      = miso_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_ram_gen.sv
// Self-checking bench for spi_slave_ram_gen: directed frames plus random frames
// compared against an abstract model of memory, address pointers and frame legality.
module tb_spi_slave_ram_gen;
  import spi_ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst, SS_n, MOSI, MISO, frame_err;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  // Abstract model state
  bit [7:0] m_mem [DEPTH];
  bit       m_memv [DEPTH];
  int       m_wr = 0;
  int       m_rd = 0;
  bit       m_valid = 0;

  // frame_err observation across a frame
  int err_pulses, err_run, err_max;

  spi_slave_ram_gen #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH),
    .AUTO_INC  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_err) begin
      err_pulses++;
      err_run++;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  endtask

  // Apply one frame to the model; returns expected error and read word.
  task automatic model_frame(input bit sel, input bit [1:0] cmd, input bit [7:0] data,
                             input bit aborted, output bit exp_err,
                             output bit [7:0] exp_word, output bit known);
    bit ok;
    exp_err  = 0;
    exp_word = 0;
    known    = 1;
    if (aborted) begin
      exp_err = 1;
      return;
    end
    if (!sel)          ok = (cmd < 2);
    else if (!m_valid) ok = (cmd == 2);
    else               ok = (cmd == 3);
    if (!ok) begin
      exp_err = 1;
      return;
    end
    case (cmd)
      2'd0: m_wr = data % DEPTH;
      2'd1: begin
        m_mem[m_wr]  = data;
        m_memv[m_wr] = 1;
        m_wr = (m_wr + 1) % DEPTH;
      end
      2'd2: begin
        m_rd    = data % DEPTH;
        m_valid = 1;
      end
      default: begin
        exp_word = m_mem[m_rd];
        known    = m_memv[m_rd];
        m_rd     = (m_rd + 1) % DEPTH;
        m_valid  = 0;
      end
    endcase
  endtask

  task automatic do_frame(input bit sel, input bit [1:0] cmd, input bit [7:0] data, input int abort_at);
    bit [9:0] bits;
    bit       aborted;
    bit [7:0] word;
    bit       tail;
    bit       exp_err, known;
    bit [7:0] exp_word;
    bits    = {cmd, data};
    aborted = (abort_at >= 0 && abort_at < 10);
    word    = 0;
    tail    = 0;
    err_pulses = 0; err_run = 0; err_max = 0;
    model_frame(sel, cmd, data, aborted, exp_err, exp_word, known);

    SS_n = 0; MOSI = 0;
    step();
    MOSI = sel;
    step();
    for (int i = 0; i < 10; i++) begin
      if (aborted && i == abort_at) begin
        SS_n = 1;
        step();
        check("abort_state", dut.state_reg, IDLE);
        break;
      end
      MOSI = bits[9-i];
      step();
    end
    if (!aborted) begin
      step();
      for (int k = 0; k < 8; k++) begin
        step();
        word[7-k] = MISO;
      end
      step();
      tail = MISO;
      SS_n = 1;
    end
    step();
    step();

    frame_no++;
    $display("frame %0d: sel=%0d cmd=%0d data=0x%02h abort_at=%0d err_pulses=%0d miso_word=0x%02h",
             frame_no, sel, cmd, data, abort_at, err_pulses, word);
    check("err_pulses", err_pulses, exp_err);
    check("err_width", err_max, exp_err);
    if (!aborted) begin
      if (known) check("miso_word", word, exp_word);
      check("miso_tail", tail, 0);
    end
    check("end_state", dut.state_reg, IDLE);
    check("wr_addr", dut.wr_addr_reg, m_wr);
    check("rd_addr", dut.rd_addr_reg, m_rd);
    check("rd_valid", dut.rd_addr_valid_reg, m_valid);
  endtask

  initial begin
    bit       sel;
    bit [1:0] cmd;
    int       ab;

    rst = 1; SS_n = 1; MOSI = 0;
    repeat (3) step();
    check("rst_miso", MISO, 0);
    check("rst_err", frame_err, 0);
    check("rst_state", dut.state_reg, IDLE);
    check("rst_wr_addr", dut.wr_addr_reg, 0);
    check("rst_rd_addr", dut.rd_addr_reg, 0);
    check("rst_rd_valid", dut.rd_addr_valid_reg, 0);
    rst = 0;
    step();

    // Write 0xA5 at 0xFF, read it back as 1,0,1,0,0,1,0,1
    do_frame(0, CMD_WR_ADDR, 8'hFF, -1);
    do_frame(0, CMD_WR_DATA, 8'hA5, -1);
    do_frame(1, CMD_RD_ADDR, 8'hFF, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);

    // Auto-increment wrap of the write pointer
    do_frame(0, CMD_WR_ADDR, 8'hFF, -1);
    do_frame(0, CMD_WR_DATA, 8'h11, -1);
    do_frame(0, CMD_WR_DATA, 8'h22, -1);
    do_frame(1, CMD_RD_ADDR, 8'hFF, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);
    do_frame(1, CMD_RD_ADDR, 8'h00, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);

    // Aborted write after 5 payload bits, abort on the final bit, then check RAM untouched
    do_frame(0, CMD_WR_DATA, 8'h77, 5);
    do_frame(0, CMD_WR_DATA, 8'h77, 9);
    do_frame(1, CMD_RD_ADDR, 8'h01, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);

    // Illegal commands
    do_frame(0, CMD_RD_ADDR, 8'h33, -1);
    do_frame(1, CMD_RD_DATA, 8'h10, -1);
    do_frame(1, CMD_RD_ADDR, 8'h00, -1);
    do_frame(1, CMD_RD_ADDR, 8'h44, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);

    // Fill the whole RAM so every later read has a known value
    do_frame(0, CMD_WR_ADDR, 8'h00, -1);
    for (int i = 0; i < DEPTH; i++) do_frame(0, CMD_WR_DATA, 8'($urandom), -1);

    // Random frames
    for (int i = 0; i < 80; i++) begin
      sel = 1'($urandom);
      if ($urandom_range(3) != 0) cmd = !sel ? 2'($urandom_range(1)) : (m_valid ? 2'd3 : 2'd2);
      else                        cmd = 2'($urandom);
      ab = ($urandom_range(7) == 0) ? int'($urandom_range(9)) : -1;
      do_frame(sel, cmd, 8'($urandom), ab);
    end

    // Reset in the middle of a readout
    do_frame(1, CMD_RD_ADDR, 8'h05, -1);
    err_pulses = 0; err_run = 0; err_max = 0;
    SS_n = 0; MOSI = 0; step();
    MOSI = 1; step();
    for (int i = 0; i < 10; i++) begin
      MOSI = (i < 2);
      step();
    end
    step();
    repeat (3) step();
    rst = 1;
    step();
    $display("frame %0d: reset during readout", frame_no + 1);
    check("mid_rst_miso", MISO, 0);
    check("mid_rst_err", frame_err, 0);
    check("mid_rst_state", dut.state_reg, IDLE);
    check("mid_rst_wr_addr", dut.wr_addr_reg, 0);
    check("mid_rst_rd_addr", dut.rd_addr_reg, 0);
    check("mid_rst_rd_valid", dut.rd_addr_valid_reg, 0);
    check("mid_rst_bit_cnt", dut.bit_cnt_reg, 0);
    check("mid_rst_shift", dut.shift_reg, 0);
    rst = 0; SS_n = 1;
    step();
    step();
    check("mid_rst_no_err", err_pulses, 0);
    m_wr = 0; m_rd = 0; m_valid = 0;
    // RAM survives reset
    do_frame(1, CMD_RD_ADDR, 8'h05, -1);
    do_frame(1, CMD_RD_DATA, 8'h00, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ram_gen.md
SPI_SLAVE_RAM_GEN -- requirements
Module: spi_slave_ram_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: RAM word width and frame payload width.
REQ-002 SHALL have parameter ADDR_W, default 8: RAM address width; legal only when ADDR_W <= DATA_W.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: RAM depth; legal only when MEM_DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter AUTO_INC, default 1: 1 post-increments an address after each data access; 0 holds it.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port SS_n, input, 1: slave select, active low.
REQ-008 SHALL have port MOSI, input, 1: serial data in, MSB first.
REQ-009 SHALL have port MISO, output, 1: serial read data out, MSB first.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on an aborted or illegal frame.

Function
REQ-011 SHALL have an FSM with states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 SHALL go IDLE->CHK_CMD on an edge with SS_n=0. In CHK_CMD, MOSI=0 SHALL go to WRITE; MOSI=1 with rd_addr_valid=0 SHALL go to READ_ADD; MOSI=1 with rd_addr_valid=1 SHALL go to READ_DATA.
REQ-013 SHALL shift DATA_W+2 payload bits, one per edge, while SS_n=0; the first two bits are cmd, the rest are data (address = low ADDR_W bits).
REQ-014 SHALL decode cmd on the cycle after the last bit: 00 loads wr_addr, 01 writes RAM[wr_addr], 10 loads rd_addr and sets rd_addr_valid, 11 reads RAM[rd_addr].
REQ-015 SHALL accept cmd 0x only in WRITE, 10 only in READ_ADD and 11 only in READ_DATA; any other cmd SHALL cause no action and a frame_err pulse.
REQ-016 For cmd 11, the RAM read SHALL take 1 cycle; MISO SHALL then drive data bits DATA_W-1..0 on DATA_W consecutive cycles, then 0; rd_addr_valid SHALL clear.
REQ-017 With AUTO_INC=1, wr_addr SHALL increment after each 01 and rd_addr after each 11, wrapping MEM_DEPTH-1 -> 0.
REQ-018 If SS_n rises before the payload is complete, the FSM SHALL go to IDLE on that edge, drop the partial payload without changing RAM or addresses, and pulse frame_err.
REQ-019 SS_n=1 on the final payload edge SHALL count as an abort; SS_n rising after completion SHALL return to IDLE without error, and MISO SHALL be forced to 0 at once even mid-readout.
REQ-020 MISO SHALL be 0 in every state other than the REQ-016 readout window.
REQ-021 Every completed frame SHALL need SS_n to go high, then low again, before the next frame.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, MISO=0, frame_err=0, wr_addr=0, rd_addr=0, rd_addr_valid=0, bit counter=0, shift register=0.
REQ-023 RAM contents SHALL NOT be reset; rst SHALL take priority over SS_n at the same edge, and rst mid-frame SHALL abort the frame without a frame_err pulse.

Structure
REQ-024 Package spi_ram_pkg SHALL hold the state enum and the cmd localparams (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11).
REQ-025 The RAM SHALL be sub-module spi_ram_sp: single-port, parametrised by DATA_W/ADDR_W/MEM_DEPTH, with synchronous write and 1-cycle registered read.
REQ-026 The FSM, shift register, counters and address registers SHALL live in spi_slave_ram_gen.

Verification
REQ-027 Write frame 0,00,0xFF then write frame 0,01,0xA5 -> RAM[255]=0xA5; frame_err stays 0.
REQ-028 Read-address frame 1,10,0xFF then read-data frame 1,11,0x00 -> after 1 cycle, MISO=1,0,1,0,0,1,0,1; rd_addr_valid=0 afterwards.
REQ-029 AUTO_INC=1: write address 0xFF, then data 0x11 and 0x22 -> RAM[255]=0x11, RAM[0]=0x22 (wrap).
REQ-030 SS_n rises after 5 payload bits of a 01 frame -> RAM unchanged, frame_err high for exactly 1 cycle, state IDLE.
REQ-031 Illegal frame 0,10,0x33 -> no RAM/address change, frame_err pulse; rst asserted mid-readout -> MISO=0 next edge, all registers at reset values.
